// File: rtl/ahb_params_pkg.sv
// ahb_params_pkg: AHB transfer/burst/response encodings and arbiter state
package ahb_params_pkg;
  typedef enum logic [1:0] {TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ} htrans_t;
  typedef enum logic [2:0] {
    BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
    BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
  } hburst_t;
  typedef enum logic [1:0] {RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT} hresp_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_LOCK} arb_state_t;
  function automatic logic [3:0] burst_beats(logic [2:0] b);
    return b[2:1] == 2'b01 ? 4'd3 : b[2:1] == 2'b10 ? 4'd7 : b[2:1] == 2'b11 ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb_multi_arbiter_if.sv
// ahb_multi_arbiter_if: request/grant and transfer-status signals seen by the arbiter
interface ahb_multi_arbiter_if import ahb_params_pkg::*; #(parameter int NO_OF_MASTERS = 4);
  localparam int MW = $clog2(NO_OF_MASTERS);
  logic [NO_OF_MASTERS-1:0] HBUSREQ;
  logic [NO_OF_MASTERS-1:0] HLOCK;
  logic [NO_OF_MASTERS-1:0] HSPLIT;
  htrans_t HTRANS;
  hburst_t HBURST;
  logic HREADY;
  hresp_t HRESP;
  logic [NO_OF_MASTERS-1:0] HGRANT;
  logic [MW-1:0] HMASTER;
  logic HMASTLOCK;
  modport master (
    output HBUSREQ, HLOCK, HSPLIT, HTRANS, HBURST, HREADY, HRESP,
    input HGRANT, HMASTER, HMASTLOCK
  );
  modport slave (
    input HBUSREQ, HLOCK, HSPLIT, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_select.sv
// ahb_rr_select: one-hot pick of eligible masters, lowest index or round-robin after pointer
module ahb_rr_select #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] pointer,
  input  logic         mode,
  output logic [N-1:0] grant
);
  logic [W-1:0] idx;
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'(mode ? (int'(pointer) + 1 + i) % N : i);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_multi_arbiter.sv
// ahb_multi_arbiter: AHB bus arbiter with burst tracking, locked sequences and split masking
module ahb_multi_arbiter import ahb_params_pkg::*; #(
  parameter int NO_OF_MASTERS = 4,
  parameter int ARB_MODE = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_multi_arbiter_if.slave bus
);
  localparam int W = $clog2(NO_OF_MASTERS);
  localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [W-1:0] DEF_IDX = W'(DEFAULT_MASTER);
  arb_state_t state, state_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic [NO_OF_MASTERS-1:0] split_mask, mask_nxt, eligible, sel, grant_nxt;
  logic [W-1:0] rr_ptr, gidx, sel_idx;
  logic split, term, rearb;
  ahb_rr_select #(.N(NO_OF_MASTERS), .W(W)) u_sel (
    .eligible(eligible),
    .pointer(rr_ptr),
    .mode(ARB_MODE != 0),
    .grant(sel)
  );
  always_comb begin
    gidx = '0;
    sel_idx = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (bus.HGRANT[i]) gidx = W'(i);
      if (sel[i]) sel_idx = W'(i);
    end
  end
  assign split = bus.HRESP == RESP_SPLIT;
  assign term = bus.HRESP != RESP_OKAY;
  assign mask_nxt = (split_mask | (bus.HREADY && split ? NO_OF_MASTERS'(1) << bus.HMASTER : '0)) & ~bus.HSPLIT;
  assign eligible = bus.HBUSREQ & ~mask_nxt;
  assign grant_nxt = rearb ? (|eligible ? sel : DEF_GRANT) : bus.HGRANT;
  always_comb begin
    state_nxt = state;
    beat_nxt = beat_cnt;
    rearb = 1'b0;
    if (bus.HLOCK[gidx] && !split) begin
      state_nxt = ARB_LOCK;
      beat_nxt = '0;
    end else if (term || state == ARB_LOCK) begin
      state_nxt = ARB_IDLE;
      beat_nxt = '0;
      rearb = 1'b1;
    end else if (bus.HTRANS == TRANS_BUSY) begin
      state_nxt = state;
    end else if (state == ARB_BURST && bus.HTRANS == TRANS_SEQ) begin
      beat_nxt = beat_cnt - 4'd1;
      rearb = beat_cnt == 4'd1;
      state_nxt = beat_cnt == 4'd1 ? ARB_IDLE : ARB_BURST;
    end else if (state == ARB_IDLE && bus.HTRANS == TRANS_NONSEQ && burst_beats(bus.HBURST) != 4'd0) begin
      state_nxt = ARB_BURST;
      beat_nxt = burst_beats(bus.HBURST);
    end else begin
      state_nxt = ARB_IDLE;
      beat_nxt = '0;
      rearb = 1'b1;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ARB_IDLE;
      beat_cnt <= '0;
      split_mask <= '0;
      rr_ptr <= DEF_IDX;
      bus.HGRANT <= DEF_GRANT;
      bus.HMASTER <= DEF_IDX;
      bus.HMASTLOCK <= 1'b0;
    end else begin
      split_mask <= mask_nxt;
      if (bus.HREADY) begin
        state <= state_nxt;
        beat_cnt <= beat_nxt;
        bus.HGRANT <= grant_nxt;
        bus.HMASTER <= gidx;
        bus.HMASTLOCK <= bus.HLOCK[gidx];
        if (rearb && |eligible) rr_ptr <= sel_idx;
      end
    end
  end
endmodule

// File: tb/tb_ahb_multi_arbiter.sv
// tb_ahb_multi_arbiter: directed checks of rotation, bursts, locking, split masking, stalls and reset
module tb_ahb_multi_arbiter;
  import ahb_params_pkg::*;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int compared = 0;
  int mismatched = 0;
  ahb_multi_arbiter_if #(.NO_OF_MASTERS(4)) bus ();
  ahb_multi_arbiter #(.NO_OF_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );
  always #5 HCLK = ~HCLK;
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_bus(input string tag, input logic [3:0] g, input logic [1:0] m, input logic l);
    check({tag, ".grant"}, 16'(bus.HGRANT), 16'(g));
    check({tag, ".master"}, 16'(bus.HMASTER), 16'(m));
    check({tag, ".mastlock"}, 16'(bus.HMASTLOCK), 16'(l));
  endtask
  initial begin
    bus.HBUSREQ = 4'b0000;
    bus.HLOCK = 4'b0000;
    bus.HSPLIT = 4'b0000;
    bus.HTRANS = TRANS_IDLE;
    bus.HBURST = BURST_SINGLE;
    bus.HREADY = 1'b1;
    bus.HRESP = RESP_OKAY;
    #12;
    expect_bus("reset", 4'b0001, 2'd0, 1'b0);
    tick();
    HRESETn = 1'b1;
    bus.HBUSREQ = 4'b1111;
    bus.HTRANS = TRANS_NONSEQ;
    tick(); expect_bus("rr1", 4'b0010, 2'd0, 1'b0);
    tick(); expect_bus("rr2", 4'b0100, 2'd1, 1'b0);
    tick(); expect_bus("rr3", 4'b1000, 2'd2, 1'b0);
    tick(); expect_bus("rr4", 4'b0001, 2'd3, 1'b0);
    tick(); check("pre_burst_a", 16'(bus.HGRANT), 16'b0010);
    tick(); check("pre_burst_b", 16'(bus.HGRANT), 16'b0100);
    bus.HBURST = BURST_INCR4;
    tick(); expect_bus("incr4_nonseq", 4'b0100, 2'd2, 1'b0);
    bus.HTRANS = TRANS_SEQ;
    tick(); check("incr4_seq1", 16'(bus.HGRANT), 16'b0100);
    bus.HTRANS = TRANS_BUSY;
    tick(); check("incr4_busy", 16'(bus.HGRANT), 16'b0100);
    bus.HTRANS = TRANS_SEQ;
    tick(); check("incr4_seq2", 16'(bus.HGRANT), 16'b0100);
    tick(); expect_bus("incr4_end", 4'b1000, 2'd2, 1'b0);
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_SINGLE;
    tick(); check("pre_lock_a", 16'(bus.HGRANT), 16'b0001);
    tick(); check("pre_lock_b", 16'(bus.HGRANT), 16'b0010);
    bus.HLOCK = 4'b0010;
    bus.HBURST = BURST_INCR8;
    tick(); expect_bus("lock_start", 4'b0010, 2'd1, 1'b1);
    bus.HTRANS = TRANS_SEQ;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lock_hold", 16'(bus.HGRANT), 16'b0010);
    end
    bus.HLOCK = 4'b0000;
    bus.HREADY = 1'b0;
    tick(); expect_bus("lock_stall", 4'b0010, 2'd1, 1'b1);
    bus.HREADY = 1'b1;
    tick(); expect_bus("lock_release", 4'b0100, 2'd1, 1'b0);
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_SINGLE;
    tick(); check("pre_split_a", 16'(bus.HGRANT), 16'b1000);
    tick(); expect_bus("pre_split_b", 4'b0001, 2'd3, 1'b0);
    bus.HRESP = RESP_SPLIT;
    tick(); expect_bus("split_edge", 4'b0010, 2'd0, 1'b0);
    bus.HRESP = RESP_OKAY;
    tick(); check("split_m1", 16'(bus.HGRANT), 16'b0100);
    tick(); check("split_skip3", 16'(bus.HGRANT), 16'b0001);
    bus.HSPLIT = 4'b1000;
    tick(); check("hsplit_edge", 16'(bus.HGRANT), 16'b0010);
    bus.HSPLIT = 4'b0000;
    tick(); check("unsplit_a", 16'(bus.HGRANT), 16'b0100);
    tick(); check("unsplit_m3", 16'(bus.HGRANT), 16'b1000);
    bus.HREADY = 1'b0;
    bus.HBUSREQ = 4'b0101;
    tick(); expect_bus("stall1", 4'b1000, 2'd2, 1'b0);
    bus.HBUSREQ = 4'b0000;
    tick(); expect_bus("stall2", 4'b1000, 2'd2, 1'b0);
    tick(); expect_bus("stall3", 4'b1000, 2'd2, 1'b0);
    bus.HREADY = 1'b1;
    tick(); expect_bus("default", 4'b0001, 2'd3, 1'b0);
    bus.HBUSREQ = 4'b1111;
    tick(); check("ptr_kept", 16'(bus.HGRANT), 16'b0001);
    tick(); check("ptr_next", 16'(bus.HGRANT), 16'b0010);
    bus.HLOCK = 4'b0010;
    bus.HBURST = BURST_INCR16;
    tick(); expect_bus("incr16_lock", 4'b0010, 2'd1, 1'b1);
    bus.HTRANS = TRANS_SEQ;
    tick(); expect_bus("incr16_seq", 4'b0010, 2'd1, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    expect_bus("mid_reset", 4'b0001, 2'd0, 1'b0);
    tick(); check("in_reset", 16'(bus.HGRANT), 16'b0001);
    HRESETn = 1'b1;
    bus.HLOCK = 4'b0000;
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_SINGLE;
    tick(); expect_bus("post_reset", 4'b0010, 2'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ahb_multi_arbiter.md
AHB_MULTI_ARBITER -- requirements
Module: ahb_multi_arbiter

Interface
REQ-001 SHALL have parameter NO_OF_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter ARB_MODE, default 1, 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, master granted when no eligible request exists.
REQ-004 SHALL have port HCLK  input  1  bus clock; sole clock, all state on rising edge.
REQ-005 SHALL have port HRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port HBUSREQ  input  NO_OF_MASTERS  per-master bus request.
REQ-007 SHALL have port HLOCK  input  NO_OF_MASTERS  per-master locked-sequence request.
REQ-008 SHALL have port HSPLIT  input  NO_OF_MASTERS  slave split-completion pulses, one bit per master.
REQ-009 SHALL have port HTRANS  input  2  current transfer type (IDLE, BUSY, NONSEQ, SEQ).
REQ-010 SHALL have port HBURST  input  3  current burst type.
REQ-011 SHALL have port HREADY  input  1  transfer-accept / wait-state indication.
REQ-012 SHALL have port HRESP  input  2  slave response (OKAY, ERROR, RETRY, SPLIT).
REQ-013 SHALL have port HGRANT  output  NO_OF_MASTERS  registered one-hot bus grant.
REQ-014 SHALL have port HMASTER  output  clog2(NO_OF_MASTERS)  index of master owning the address phase.
REQ-015 SHALL have port HMASTLOCK  output  1  current address phase is part of a locked sequence.

Function
REQ-016 SHALL keep HGRANT one-hot at all times; HGRANT, HMASTER and HMASTLOCK SHALL update only on HCLK edges where HREADY=1.
REQ-017 SHALL load HMASTER with the index of HGRANT, and HMASTLOCK with HLOCK[that index], on each HREADY=1 edge (one-cycle lag behind grant).
REQ-018 SHALL run FSM ARB_IDLE / ARB_BURST / ARB_LOCK; re-arbitration allowed only in ARB_IDLE or at the burst-end edge.
REQ-019 SHALL, in ARB_IDLE on an accepted NONSEQ (HREADY=1) with HBURST INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16, load beat_cnt with 3, 7, 15 and enter ARB_BURST.
REQ-020 SHALL decrement beat_cnt on each accepted SEQ; the edge accepting the beat that makes beat_cnt 0 SHALL be the re-arbitration edge, FSM returning to ARB_IDLE.
REQ-021 SHALL treat SINGLE and INCR as re-arbitrable at every accepted transfer; BUSY SHALL neither decrement nor re-arbitrate.
REQ-022 SHALL abandon ARB_BURST (to ARB_IDLE, re-arbitrate) on accepted IDLE or NONSEQ before beat_cnt reaches 0.
REQ-023 SHALL enter ARB_LOCK while HLOCK of the granted master is 1, holding grant until HLOCK falls and a transfer is accepted with HLOCK=0; locking overrides burst end.
REQ-024 SHALL, on HRESP=SPLIT with HREADY=1, set split_mask[HMASTER], terminate any burst/lock and re-arbitrate that edge.
REQ-025 SHALL clear split_mask[i] on HSPLIT[i]=1; set and clear on the same edge SHALL resolve to clear.
REQ-026 SHALL treat RETRY and ERROR (HREADY=1) as burst termination with re-arbitration; ERROR SHALL NOT mask.
REQ-027 SHALL select among eligible = HBUSREQ & ~split_mask: fixed mode lowest index; round-robin from (last granted + 1) mod NO_OF_MASTERS, wrapping.
REQ-028 SHALL grant DEFAULT_MASTER when eligible is zero, even if DEFAULT_MASTER is split-masked.
REQ-029 SHALL update the round-robin pointer only when grant changes to a requesting master.

Reset
REQ-030 SHALL, while HRESETn=0, drive HGRANT one-hot at DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, split_mask=0, beat_cnt=0, RR pointer=DEFAULT_MASTER, FSM ARB_IDLE.
REQ-031 SHALL abandon any burst, lock or split state on reset mid-operation; first grant decision after release is made at the first HREADY=1 edge.

Structure
REQ-032 SHALL take HTRANS, HBURST, HRESP encodings and the arbiter state enum from ahb_params_pkg.
REQ-033 SHALL place the masked priority selector in one sub-module ahb_rr_select (inputs eligible, pointer, mode; output one-hot).

Verification (NO_OF_MASTERS=4, ARB_MODE=1, DEFAULT_MASTER=0)
REQ-034 SHALL check: HBUSREQ=4'b1111 held, SINGLE transfers, HREADY=1 -> HGRANT sequence 0010,0100,1000,0001; HMASTER follows one cycle later.
REQ-035 SHALL check: master 2 INCR4 NONSEQ+3 SEQ, all others requesting -> HGRANT stays 0100 through the accept edge of beat 4, then changes to 1000.
REQ-036 SHALL check: master 1 HLOCK=1 with INCR8 and others requesting -> grant held, HMASTLOCK=1, release only after accepted transfer with HLOCK=0.
REQ-037 SHALL check: HRESP=SPLIT for master 3 -> master 3 not granted despite HBUSREQ[3]=1 until HSPLIT[3] pulse, then eligible next arbitration.
REQ-038 SHALL check: HBUSREQ=0, HREADY=0 for 3 cycles during request change -> HGRANT frozen; HRESETn low mid-INCR16 -> HGRANT=0001, HMASTLOCK=0 immediately.
